// File: rtl/mem_trace_buf.sv
// Capture buffer for the memory write bus: filters writes by address window,
// stamps them with a free-running cycle count and queues them for a
// valid/ready consumer. Writes that find the queue full are counted, not stalled.
module mem_trace_buf #(
  parameter int unsigned ADDR_WID = 32,
  parameter int unsigned DATA_WID = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_WID   = 16,
  parameter int unsigned CNT_WID  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_we,
  input  logic [ADDR_WID-1:0]     mem_addr,
  input  logic [DATA_WID-1:0]     mem_data,
  input  logic                    filt_en,
  input  logic [ADDR_WID-1:0]     filt_lo,
  input  logic [ADDR_WID-1:0]     filt_hi,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WID-1:0]     out_addr,
  output logic [DATA_WID-1:0]     out_data,
  output logic [TS_WID-1:0]       out_ts,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNT_WID-1:0]      drop_cnt,
  input  logic                    clr_ovf
);

  localparam int unsigned IDX_WID = $clog2(DEPTH);
  localparam int unsigned PTR_WID = IDX_WID + 1;

  typedef struct packed {
    logic [ADDR_WID-1:0] addr;
    logic [DATA_WID-1:0] data;
    logic [TS_WID-1:0]   ts;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               wr_entry;
  entry_t               head;

  logic [PTR_WID-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WID-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TS_WID-1:0]    ts_q, ts_d;
  logic [CNT_WID-1:0]   drop_cnt_q, drop_cnt_d;
  logic                 overflow_q, overflow_d;

  logic in_win, hit, empty, full, pop, push, drop;

  // Qualify the bus write, decide push/pop/drop and compute next state.
  always_comb begin
    in_win     = (filt_lo <= mem_addr) && (mem_addr <= filt_hi);
    hit        = mem_we && (!filt_en || in_win);
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[IDX_WID-1:0] == rd_ptr_q[IDX_WID-1:0]) &&
                 (wr_ptr_q[IDX_WID] != rd_ptr_q[IDX_WID]);
    pop        = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push       = hit && (!full || pop);
    drop       = hit && full && !pop;

    wr_entry.addr = mem_addr;
    wr_entry.data = mem_data;
    wr_entry.ts   = ts_q;

    wr_ptr_d   = wr_ptr_q + PTR_WID'(push);
    rd_ptr_d   = rd_ptr_q + PTR_WID'(pop);
    ts_d       = ts_q + TS_WID'(1);

    // Clear takes effect before a same-cycle drop is counted.
    drop_cnt_d = clr_ovf ? '0 : drop_cnt_q;
    overflow_d = clr_ovf ? 1'b0 : overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + CNT_WID'(1);
    end
  end

  // Control state: pointers, timestamp and overflow bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ts_q       <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ts_q       <= ts_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; unreset, the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[IDX_WID-1:0]] <= wr_entry;
  end

  // Head presentation and status, all derived from registered state.
  always_comb begin
    head      = mem_q[rd_ptr_q[IDX_WID-1:0]];
    out_valid = !empty;
    out_addr  = empty ? '0 : head.addr;
    out_data  = empty ? '0 : head.data;
    out_ts    = empty ? '0 : head.ts;
    level     = wr_ptr_q - rd_ptr_q;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_mem_trace_buf.sv
// Bench for mem_trace_buf: reference queue model plus per-scenario tasks.
module tb_mem_trace_buf;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TW = 4;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_data = '0;
  logic filt_en = 1'b0;
  logic [AW-1:0] filt_lo = '0;
  logic [AW-1:0] filt_hi = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_ts;
  logic [4:0] level;
  logic overflow;
  logic [CW-1:0] drop_cnt;
  logic clr_ovf = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  ent_t sb[$];
  logic [TW-1:0] m_ts;
  logic [CW-1:0] m_drop;
  logic m_ovf;

  mem_trace_buf #(.ADDR_WID(AW), .DATA_WID(DW), .DEPTH(DEPTH), .TS_WID(TW), .CNT_WID(CW)) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .filt_en(filt_en), .filt_lo(filt_lo), .filt_hi(filt_hi),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_ts(out_ts), .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: push expected entries on capture, pop on acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      m_ts = '0;
      m_drop = '0;
      m_ovf = 1'b0;
    end else begin
      logic hit, pop, full, drop;
      ent_t e;
      hit  = mem_we && (!filt_en || (filt_lo <= mem_addr && mem_addr <= filt_hi));
      pop  = (sb.size() != 0) && out_ready;
      full = (sb.size() == DEPTH);
      drop = hit && full && !pop;
      if (clr_ovf) begin m_drop = '0; m_ovf = 1'b0; end
      if (drop) begin
        m_ovf = 1'b1;
        if (m_drop != '1) m_drop = m_drop + 16'd1;
      end
      if (pop) void'(sb.pop_front());
      if (hit && !drop) begin
        e.a = mem_addr; e.d = mem_data; e.t = m_ts;
        sb.push_back(e);
      end
      m_ts = m_ts + 4'd1;
    end
  end

  // Mid-cycle comparison of DUT state against the model.
  always @(negedge clk) begin
    if (!rst) begin
      n_total++;
      if (out_valid !== (sb.size() != 0)) $display("FAIL sb_valid: got %b want %b", out_valid, sb.size() != 0);
      else n_pass++;
      n_total++;
      if (level !== 5'(sb.size())) $display("FAIL sb_level: got %0d want %0d", level, sb.size());
      else n_pass++;
      n_total++;
      if (drop_cnt !== m_drop || overflow !== m_ovf)
        $display("FAIL sb_ovf: got cnt=%0d ovf=%b want cnt=%0d ovf=%b", drop_cnt, overflow, m_drop, m_ovf);
      else n_pass++;
      if (sb.size() != 0) begin
        n_total++;
        if ({out_addr, out_data, out_ts} !== sb[0])
          $display("FAIL sb_head: got a=%h d=%h t=%h want a=%h d=%h t=%h",
                   out_addr, out_data, out_ts, sb[0].a, sb[0].d, sb[0].t);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    tick();
    mem_we = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL drain_timeout: out_valid=%b after %0d cycles want 0", out_valid, n);
    else n_pass++;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({out_valid, level, overflow, drop_cnt} !== '0 || {out_addr, out_data, out_ts} !== '0)
      $display("FAIL reset_state: got v=%b lvl=%0d ovf=%b cnt=%0d a=%h d=%h t=%h want all 0",
               out_valid, level, overflow, drop_cnt, out_addr, out_data, out_ts);
    else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    repeat (5) tick();
    mem_we = 1'b1; mem_addr = 32'h10; mem_data = 32'hA;
    tick();
    mem_addr = 32'h14; mem_data = 32'hB;
    tick();
    mem_we = 1'b0;
    @(negedge clk);
    n_total++;
    if (level !== 5'd2) $display("FAIL basic_level: got %0d want 2", level); else n_pass++;
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (out_ts !== 4'd5 || out_data !== 32'hA) $display("FAIL basic_first: got ts=%0d d=%h want ts=5 d=a", out_ts, out_data);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (out_ts !== 4'd6 || out_data !== 32'hB) $display("FAIL basic_second: got ts=%0d d=%h want ts=6 d=b", out_ts, out_data);
    else n_pass++;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL basic_empty: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_filter();
    logic [AW-1:0] addrs [4];
    addrs[0] = 32'hFF; addrs[1] = 32'h100; addrs[2] = 32'h1FF; addrs[3] = 32'h200;
    tick();
    filt_en = 1'b1; filt_lo = 32'h100; filt_hi = 32'h1FF;
    for (int i = 0; i < 4; i++) begin
      mem_we = 1'b1; mem_addr = addrs[i]; mem_data = 32'h200 + 32'(i);
      tick();
    end
    // inverted window qualifies nothing
    filt_lo = 32'h200; filt_hi = 32'h100; mem_addr = 32'h180;
    tick();
    mem_we = 1'b0;
    @(negedge clk);
    n_total++;
    if (level !== 5'd2 || out_addr !== 32'h100)
      $display("FAIL filter_queue: got lvl=%0d head=%h want lvl=2 head=100", level, out_addr);
    else n_pass++;
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    n_total++;
    if (out_addr !== 32'h1FF) $display("FAIL filter_second: got %h want 1ff", out_addr); else n_pass++;
    filt_en = 1'b0;
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) begin
      mem_we = 1'b1; mem_addr = 32'h1000 + 32'(i); mem_data = 32'hC000 + 32'(i);
      tick();
    end
    mem_we = 1'b0;
    @(negedge clk);
    n_total++;
    if (level !== 5'd16 || drop_cnt !== 16'd4 || overflow !== 1'b1 || out_addr !== 32'h1000)
      $display("FAIL ovf_full: got lvl=%0d cnt=%0d ovf=%b head=%h want 16 4 1 1000", level, drop_cnt, overflow, out_addr);
    else n_pass++;
    tick();
    clr_ovf = 1'b1; mem_we = 1'b1; mem_addr = 32'h1014; mem_data = 32'hC014;
    tick();
    clr_ovf = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    n_total++;
    if (drop_cnt !== 16'd1 || overflow !== 1'b1)
      $display("FAIL ovf_clr_drop: got cnt=%0d ovf=%b want 1 1", drop_cnt, overflow);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem_we = 1'b1; mem_addr = 32'h2000 + 32'(i); mem_data = 32'hD000 + 32'(i);
      @(negedge clk);
      n_total++;
      if (level !== 5'd16) $display("FAIL b2b_level: cycle %0d got %0d want 16", i, level); else n_pass++;
      tick();
    end
    mem_we = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (drop_cnt !== 16'd1) $display("FAIL b2b_drop: got %0d want 1", drop_cnt); else n_pass++;
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    @(negedge clk);
    n_total++;
    if (drop_cnt !== 16'd0 || overflow !== 1'b0)
      $display("FAIL clr_only: got cnt=%0d ovf=%b want 0 0", drop_cnt, overflow);
    else n_pass++;
    drain();
  endtask

  task automatic test_stall_wrap();
    int sent;
    int cyc;
    sent = 0; cyc = 0;
    while (sent < 100 && cyc < 1000) begin
      mem_we = ($urandom_range(0, 1) == 1);
      mem_addr = 32'h3000 + 32'(sent);
      mem_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      if (mem_we) sent++;
      cyc++;
      tick();
    end
    n_total++;
    if (sent !== 100) $display("FAIL stall_budget: sent %0d want 100", sent); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 5; i++) begin
      mem_we = 1'b1; mem_addr = 32'h4000 + 32'(i); mem_data = 32'hE000 + 32'(i);
      tick();
    end
    mem_we = 1'b0; out_ready = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || level !== 5'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0 || out_ts !== 4'd0)
      $display("FAIL rst_mid: got v=%b lvl=%0d cnt=%0d ovf=%b ts=%0d want all 0", out_valid, level, drop_cnt, overflow, out_ts);
    else n_pass++;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    mem_we = 1'b1; mem_addr = 32'h5000; mem_data = 32'hF00D;
    tick();
    mem_we = 1'b0;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1 || out_ts !== 4'd3 || out_addr !== 32'h5000)
      $display("FAIL rst_first_ts: got v=%b ts=%0d a=%h want 1 3 5000", out_valid, out_ts, out_addr);
    else n_pass++;
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_back_to_back();
    test_stall_wrap();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
